// File: rtl/sfr_load_ctrl.sv
// -----------------------------------------------------------------------------
// sfr_load_ctrl
//   Sequencer for the serial shift register (sfr) chain. It takes a parallel
//   word over a valid/ready handshake and plays it out MSB-first as a gated
//   serial stream (o_sd qualified by o_shift_en). Once the last bit has been
//   shifted into the downstream register, o_done pulses for one cycle.
//
//   Handshake: a word is accepted on a rising i_clk edge where i_valid and
//   o_ready are both 1. The producer must hold i_data/i_valid until that edge.
//   i_valid while o_ready=0 is ignored.
//
//   Optional feature macro: SFR_LOAD_CTRL_PARITY_EN
//     defined   -> one extra shift cycle carries even parity (^word) on o_sd
//     undefined -> exactly WIDTH shift cycles, no parity logic
//
// Parameters
//   WIDTH       word width = shift bits per word (>= 2)
//   GAP_CYCLES  idle cycles forced after o_done before the next accept (0..15)
//
// Ports
//   i_clk       clock, all logic on posedge
//   i_rst_n     asynchronous active-low reset
//   i_data      parallel word to serialise
//   i_valid     i_data valid
//   o_ready     block can accept a word this cycle
//   o_sd        serial data to the shift register input
//   o_shift_en  downstream register shifts this cycle
//   o_busy      word in flight (any state but IDLE)
//   o_done      one-cycle pulse: register now holds the word
//   o_state     debug view of the FSM state
// -----------------------------------------------------------------------------
module sfr_load_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sd,
  output logic             o_shift_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SFR_LOAD_CTRL_PARITY_EN
  localparam int SHIFT_LEN = WIDTH + 1;
`else
  localparam int SHIFT_LEN = WIDTH;
`endif

  localparam logic [CW-1:0] LAST_CNT = CW'(SHIFT_LEN - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state, nxt_state;
  logic [CW-1:0]    cnt, nxt_cnt;
  logic [3:0]       gap_cnt, nxt_gap;
  logic [WIDTH-1:0] shadow, nxt_shadow;
  logic             accept;
  logic [CW-1:0]    bit_idx;
  logic [WIDTH-1:0] bit_sel;
  logic             data_bit;
  logic             nxt_sd;

  assign o_state = state;

  // Next-state, counters and the value every registered output takes after
  // the coming edge. Outputs are registered from the *next* state so that
  // they line up with the state they describe.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_gap    = gap_cnt;
    nxt_shadow = shadow;
    accept     = (state == IDLE) && o_ready && i_valid;

    case (state)
      IDLE: begin
        if (accept) begin
          nxt_shadow = i_data;
          nxt_cnt    = '0;
          nxt_state  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_CNT) begin
          nxt_state = DONE;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      DONE: begin
        nxt_gap   = '0;
        nxt_state = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          nxt_state = IDLE;
        end else begin
          nxt_gap = gap_cnt + 4'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    // MSB first: counter value c selects shadow[WIDTH-1-c]. A one-hot mask
    // keeps the select free of out-of-range indexing when c reaches WIDTH.
    bit_idx  = CW'(WIDTH - 1) - nxt_cnt;
    bit_sel  = WIDTH'(1) << bit_idx;
    data_bit = |(nxt_shadow & bit_sel);

`ifdef SFR_LOAD_CTRL_PARITY_EN
    if (nxt_cnt == CW'(WIDTH)) begin
      data_bit = ^nxt_shadow;
    end
`endif

    nxt_sd = (nxt_state == SHIFT) ? data_bit : 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      gap_cnt    <= '0;
      shadow     <= '0;
      o_ready    <= 1'b0;
      o_sd       <= 1'b0;
      o_shift_en <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      gap_cnt    <= nxt_gap;
      shadow     <= nxt_shadow;
      // o_ready stays 0 in the first IDLE cycle after reset release, then
      // rises on the first edge.
      o_ready    <= (nxt_state == IDLE);
      o_sd       <= nxt_sd;
      o_shift_en <= (nxt_state == SHIFT);
      o_busy     <= (nxt_state != IDLE);
      o_done     <= (nxt_state == DONE);
    end
  end

endmodule
